// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter: single driver of the register-file write port, merging MEM/WB writes with buffered MDU results.
// Optional macro WB_ARB_BYPASS_EN lets an MDU result skip the empty FIFO straight into the output register.
module wb_write_arbiter #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk_i,
  input  logic          rst_n,
  input  logic          pipe_we_i,
  input  logic [4:0]    pipe_addr_i,
  input  logic [31:0]   pipe_data_i,
  input  logic          mdu_valid_i,
  output logic          mdu_ready_o,
  input  logic [4:0]    mdu_addr_i,
  input  logic [31:0]   mdu_data_i,
  input  logic [4:0]    rs_addr_i,
  input  logic [4:0]    rt_addr_i,
  output logic          rs_pending_o,
  output logic          rt_pending_o,
  output logic          RegWrite_o,
  output logic [4:0]    RDaddr_o,
  output logic [31:0]   RDdata_o,
  output logic [AW:0]   fifo_count_o
);
  logic [4:0]       r_addr [DEPTH];
  logic [31:0]      r_data [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [AW-1:0]    r_wp, r_rp;
  logic [AW:0]      r_cnt;
  logic w_pipe, w_acc, w_push, w_pop, w_byp, w_rs_hit, w_rt_hit;

  assign mdu_ready_o  = r_cnt < (AW+1)'(DEPTH);
  assign fifo_count_o = r_cnt;
  assign w_pipe = pipe_we_i & (pipe_addr_i != 5'd0);
  assign w_acc  = mdu_valid_i & mdu_ready_o;
  assign w_pop  = !w_pipe & (r_cnt != '0);
`ifdef WB_ARB_BYPASS_EN
  assign w_byp  = w_acc & (mdu_addr_i != 5'd0) & (r_cnt == '0) & !w_pipe;
`else
  assign w_byp  = 1'b0;
`endif
  // Results for register 0 are consumed by the handshake but never stored.
  assign w_push = w_acc & (mdu_addr_i != 5'd0) & !w_byp;

  always_comb begin
    w_rs_hit = 1'b0;
    w_rt_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      w_rs_hit = w_rs_hit | (r_vld[i] & (r_addr[i] == rs_addr_i));
      w_rt_hit = w_rt_hit | (r_vld[i] & (r_addr[i] == rt_addr_i));
    end
  end

  assign rs_pending_o = w_rs_hit & (rs_addr_i != 5'd0);
  assign rt_pending_o = w_rt_hit & (rt_addr_i != 5'd0);

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_addr[r_wp] <= mdu_addr_i;
      r_data[r_wp] <= mdu_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_vld[r_wp] <= 1'b1;
        r_wp        <= r_wp + 1'b1;
      end
      if (w_pop) begin
        r_vld[r_rp] <= 1'b0;
        r_rp        <= r_rp + 1'b1;
      end
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      RegWrite_o <= 1'b0;
      RDaddr_o   <= '0;
      RDdata_o   <= '0;
    end else if (w_pipe) begin
      RegWrite_o <= 1'b1;
      RDaddr_o   <= pipe_addr_i;
      RDdata_o   <= pipe_data_i;
    end else if (w_pop) begin
      RegWrite_o <= 1'b1;
      RDaddr_o   <= r_addr[r_rp];
      RDdata_o   <= r_data[r_rp];
    end else if (w_byp) begin
      RegWrite_o <= 1'b1;
      RDaddr_o   <= mdu_addr_i;
      RDdata_o   <= mdu_data_i;
    end else begin
      RegWrite_o <= 1'b0;
    end
  end
endmodule

// File: tb/tb_wb_write_arbiter.sv
// tb_wb_write_arbiter: directed checks of reset, pipe writes, contention, FIFO full/wrap and the bypass option.
module tb_wb_write_arbiter;
  logic clk_i = 1'b0, rst_n = 1'b0;
  logic pipe_we_i, mdu_valid_i, mdu_ready_o, rs_pending_o, rt_pending_o, RegWrite_o;
  logic [4:0] pipe_addr_i, mdu_addr_i, rs_addr_i, rt_addr_i, RDaddr_o;
  logic [31:0] pipe_data_i, mdu_data_i, RDdata_o;
  logic [2:0] fifo_count_o;
  int n_chk = 0, n_fail = 0;

  wb_write_arbiter #(.DEPTH(4), .AW(2)) dut (
    .clk_i(clk_i), .rst_n(rst_n),
    .pipe_we_i(pipe_we_i), .pipe_addr_i(pipe_addr_i), .pipe_data_i(pipe_data_i),
    .mdu_valid_i(mdu_valid_i), .mdu_ready_o(mdu_ready_o),
    .mdu_addr_i(mdu_addr_i), .mdu_data_i(mdu_data_i),
    .rs_addr_i(rs_addr_i), .rt_addr_i(rt_addr_i),
    .rs_pending_o(rs_pending_o), .rt_pending_o(rt_pending_o),
    .RegWrite_o(RegWrite_o), .RDaddr_o(RDaddr_o), .RDdata_o(RDdata_o),
    .fifo_count_o(fifo_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic wr(input string tag, input logic [4:0] a, input logic [31:0] d);
    chk({tag, "_we"}, 32'(RegWrite_o), 32'd1);
    chk({tag, "_addr"}, 32'(RDaddr_o), 32'(a));
    chk({tag, "_data"}, RDdata_o, d);
  endtask

  initial begin
    pipe_we_i = 0; pipe_addr_i = 0; pipe_data_i = 0;
    mdu_valid_i = 0; mdu_addr_i = 0; mdu_data_i = 0;
    rs_addr_i = 0; rt_addr_i = 0;
    repeat (2) tick;
    chk("rst_we", 32'(RegWrite_o), 0);
    chk("rst_addr", 32'(RDaddr_o), 0);
    chk("rst_data", RDdata_o, 0);
    chk("rst_cnt", 32'(fifo_count_o), 0);
    chk("rst_ready", 32'(mdu_ready_o), 1);
    chk("rst_pend", 32'(rs_pending_o), 0);
    rst_n = 1;
    tick;
    // pipe only
    pipe_we_i = 1; pipe_addr_i = 8; pipe_data_i = 32'h1234;
    tick;
    wr("pipe8", 5'd8, 32'h1234);
    pipe_addr_i = 0; pipe_data_i = 32'h5555;
    tick;
    chk("pipe0_we", 32'(RegWrite_o), 0);
    chk("pipe0_addr_hold", 32'(RDaddr_o), 8);
    chk("pipe0_data_hold", RDdata_o, 32'h1234);
    // contention
    pipe_addr_i = 9; pipe_data_i = 32'h9;
    mdu_valid_i = 1; mdu_addr_i = 5; mdu_data_i = 32'hAA;
    rs_addr_i = 5; rt_addr_i = 6;
    tick;
    wr("cont9", 5'd9, 32'h9);
    chk("cont_cnt1", 32'(fifo_count_o), 1);
    chk("cont_rs_pend", 32'(rs_pending_o), 1);
    chk("cont_rt_nopend", 32'(rt_pending_o), 0);
    mdu_valid_i = 0; pipe_addr_i = 10; pipe_data_i = 32'h10;
    rt_addr_i = 5;
    #1 chk("cont_rt_pend", 32'(rt_pending_o), 1);
    tick;
    wr("cont10", 5'd10, 32'h10);
    chk("cont_rs_pend2", 32'(rs_pending_o), 1);
    pipe_we_i = 0;
    tick;
    wr("cont5", 5'd5, 32'hAA);
    chk("cont_cnt0", 32'(fifo_count_o), 0);
    chk("cont_rs_clear", 32'(rs_pending_o), 0);
    tick;
    chk("cont_idle_we", 32'(RegWrite_o), 0);
    // full, hold-off, simultaneous push/pop, pointer wrap
    pipe_we_i = 1; pipe_addr_i = 11; pipe_data_i = 32'h11;
    mdu_valid_i = 1;
    for (int i = 1; i <= 4; i++) begin
      mdu_addr_i = 5'(i); mdu_data_i = 32'h100 + 32'(i);
      tick;
      chk("full_cnt", 32'(fifo_count_o), 32'(i));
    end
    chk("full_ready", 32'(mdu_ready_o), 0);
    mdu_addr_i = 7; mdu_data_i = 32'h777; rs_addr_i = 7; rt_addr_i = 4;
    tick;
    chk("full_hold_cnt", 32'(fifo_count_o), 4);
    chk("full_hold_pend", 32'(rs_pending_o), 0);
    chk("full_rt_pend", 32'(rt_pending_o), 1);
    wr("full_pipe", 5'd11, 32'h11);
    pipe_we_i = 0;
    tick;
    wr("pop1", 5'd1, 32'h101);
    chk("pop1_cnt", 32'(fifo_count_o), 3);
    chk("pop1_ready", 32'(mdu_ready_o), 1);
    tick;
    wr("pop2", 5'd2, 32'h102);
    chk("pushpop_cnt", 32'(fifo_count_o), 3);
    chk("push7_pend", 32'(rs_pending_o), 1);
    mdu_valid_i = 0;
    tick;
    wr("pop3", 5'd3, 32'h103);
    tick;
    wr("pop4", 5'd4, 32'h104);
    chk("pop4_cnt", 32'(fifo_count_o), 1);
    chk("pop4_rt_clear", 32'(rt_pending_o), 0);
    tick;
    wr("pop7", 5'd7, 32'h777);
    chk("pop7_cnt", 32'(fifo_count_o), 0);
    chk("pop7_pend", 32'(rs_pending_o), 0);
    tick;
    chk("drain_we", 32'(RegWrite_o), 0);
    // MDU result for register 0 is consumed, never stored or written
    mdu_valid_i = 1; mdu_addr_i = 0; mdu_data_i = 32'hDEAD;
    tick;
    chk("mdu0_cnt", 32'(fifo_count_o), 0);
    chk("mdu0_we", 32'(RegWrite_o), 0);
    // reset mid-burst
    pipe_we_i = 1; pipe_addr_i = 13; pipe_data_i = 32'h13; rs_addr_i = 14;
    for (int i = 0; i < 3; i++) begin
      mdu_addr_i = 5'(14 + i); mdu_data_i = 32'h200 + 32'(i);
      tick;
    end
    chk("burst_cnt", 32'(fifo_count_o), 3);
    chk("burst_pend", 32'(rs_pending_o), 1);
    rst_n = 0;
    #1;
    chk("mrst_we", 32'(RegWrite_o), 0);
    chk("mrst_addr", 32'(RDaddr_o), 0);
    chk("mrst_cnt", 32'(fifo_count_o), 0);
    chk("mrst_pend", 32'(rs_pending_o), 0);
    chk("mrst_ready", 32'(mdu_ready_o), 1);
    pipe_we_i = 0; mdu_valid_i = 0;
    tick;
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("post_rst_we", 32'(RegWrite_o), 0);
    end
    chk("post_rst_cnt", 32'(fifo_count_o), 0);
    // bypass / no-bypass latency
    mdu_valid_i = 1; mdu_addr_i = 3; mdu_data_i = 32'h7;
    tick;
    mdu_valid_i = 0;
`ifdef WB_ARB_BYPASS_EN
    wr("byp3", 5'd3, 32'h7);
    chk("byp_cnt", 32'(fifo_count_o), 0);
`else
    chk("nobyp_we", 32'(RegWrite_o), 0);
    chk("nobyp_cnt", 32'(fifo_count_o), 1);
    tick;
    wr("nobyp3", 5'd3, 32'h7);
    chk("nobyp_cnt0", 32'(fifo_count_o), 0);
`endif
    tick;
    chk("end_we", 32'(RegWrite_o), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
